beat_sequencer: RTL and testbench

- Upstream stage of the music ROM: generates the 8-bit quarter-beat index that the tone lookup consumes.
- Divides the system clock down to a beat rate with a selectable tempo.
- Runs a play/pause/stop state machine and wraps or ends at the sequence length.
- Also provides a one-cycle beat tick and an end-of-song pulse for the tone and speaker stages downstream.

---
 rtl/beat_sequencer.sv | 159 +++++++++++++++
 tb/tb_beat_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_sequencer.sv
// beat_sequencer: quarter-beat index generator for the music ROM.
// Divides clk down to a tempo-selectable beat rate and runs an
// IDLE/PLAY/PAUSE transport. Every output is driven from a register.
// Optional feature macro: SEQ_MEASURE_SKIP_EN (skip jumps to the next
// 16-beat measure). Without the macro the skip input is ignored.
module beat_sequencer #(
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned BEAT_HZ = 8,
    parameter int unsigned LEN     = 32,
    parameter int unsigned BEAT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [1:0]        tempo_sel,
    input  logic              skip,
    output logic [BEAT_W-1:0] beat_num,
    output logic              beat_tick,
    output logic              playing,
    output logic              paused,
    output logic              done
);

    // Base beat period in clocks at tempo x1.
    localparam logic [31:0]       P         = 32'(CLK_HZ / BEAT_HZ);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_PAUSE
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       period_q, period_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;
    logic              playing_q, paused_q;

    // Tempo scaling by shifts only, so no divider is built.
    function automatic logic [31:0] period_of(input logic [1:0] sel);
        case (sel)
            2'd0:    period_of = P;
            2'd1:    period_of = P >> 1;
            2'd2:    period_of = P << 1;
            default: period_of = P >> 2;
        endcase
    endfunction

`ifdef SEQ_MEASURE_SKIP_EN
    localparam logic [BEAT_W:0] LEN_W = (BEAT_W + 1)'(LEN);

    // One extra bit so a jump past the last measure is still visible.
    logic [BEAT_W:0] measure_w;
    assign measure_w = ({1'b0, beat_q} | (BEAT_W + 1)'(15)) + (BEAT_W + 1)'(1);
`else
    logic skip_unused;
    assign skip_unused = skip;
`endif

    // Next-state, divider and beat-advance decisions.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        beat_d   = beat_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            beat_d  = '0;
            count_d = '0;
        end else if (state_q == S_IDLE) begin
            if (play) begin
                state_d  = S_PLAY;
                count_d  = '0;
                period_d = period_of(tempo_sel);
            end
        end else if (pause) begin
            // Holding count here is what suppresses a tick landing on this cycle.
            state_d = S_PAUSE;
`ifdef SEQ_MEASURE_SKIP_EN
        end else if (skip) begin
            count_d = '0;
            tick_d  = 1'b1;
            if (state_q == S_PLAY) begin
                period_d = period_of(tempo_sel);
            end
            if (measure_w < LEN_W) begin
                beat_d = measure_w[BEAT_W-1:0];
            end else begin
                beat_d = '0;
                if (!loop_en) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
        end else if (state_q == S_PAUSE) begin
            // Resume keeps the held count and the period latched before the pause.
            if (play) begin
                state_d = S_PLAY;
            end
        end else if (count_q == period_q - 32'd1) begin
            count_d  = '0;
            tick_d   = 1'b1;
            period_d = period_of(tempo_sel);
            if (beat_q < LAST_BEAT) begin
                beat_d = beat_q + BEAT_W'(1);
            end else begin
                beat_d = '0;
                if (!loop_en) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        end else begin
            count_d = count_q + 32'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            period_q  <= P;
            beat_q    <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            playing_q <= 1'b0;
            paused_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            beat_q    <= beat_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            playing_q <= (state_d == S_PLAY);
            paused_q  <= (state_d == S_PAUSE);
        end
    end

    assign beat_num  = beat_q;
    assign beat_tick = tick_q;
    assign playing   = playing_q;
    assign paused    = paused_q;
    assign done      = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Testbench for beat_sequencer with P = 4 clocks, LEN = 32.
// Directed scenarios check against hand-derived constants; a randomized
// run checks every cycle against a transport-level reference model.
module tb_beat_sequencer;

    localparam int CLK_HZ  = 16;
    localparam int BEAT_HZ = 4;
    localparam int LEN     = 32;
    localparam int BEAT_W  = 8;
    localparam int P       = CLK_HZ / BEAT_HZ;

`ifdef SEQ_MEASURE_SKIP_EN
    localparam bit SKIP_ON = 1'b1;
`else
    localparam bit SKIP_ON = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              play = 1'b0;
    logic              pause = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [1:0]        tempo_sel = 2'd0;
    logic              skip = 1'b0;
    logic [BEAT_W-1:0] beat_num;
    logic              beat_tick;
    logic              playing;
    logic              paused;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: transport mode, current beat, clocks elapsed in the
    // current beat and the length of that beat in clocks.
    int m_mode;
    int m_beat;
    int m_elapsed;
    int m_len;
    bit m_tick;
    bit m_done;

    beat_sequencer #(
        .CLK_HZ (CLK_HZ),
        .BEAT_HZ(BEAT_HZ),
        .LEN    (LEN),
        .BEAT_W (BEAT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .play     (play),
        .pause    (pause),
        .stop     (stop),
        .loop_en  (loop_en),
        .tempo_sel(tempo_sel),
        .skip     (skip),
        .beat_num (beat_num),
        .beat_tick(beat_tick),
        .playing  (playing),
        .paused   (paused),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic int beat_len(input int sel);
        case (sel)
            0:       return P;
            1:       return P / 2;
            2:       return P * 2;
            default: return P / 4;
        endcase
    endfunction

    // Beat finished (naturally or by skip) and landed past the end of the song.
    task automatic model_end_of_song();
        m_beat = 0;
        if (!loop_en) begin
            m_mode = M_IDLE;
            m_done = 1'b1;
        end
    endtask

    task automatic model_update();
        int nxt;
        m_tick = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_beat = 0; m_elapsed = 0; m_len = P;
        end else if (stop) begin
            m_mode = M_IDLE; m_beat = 0; m_elapsed = 0;
        end else if (m_mode == M_IDLE) begin
            if (play) begin
                m_mode = M_PLAY; m_elapsed = 0; m_len = beat_len(int'(tempo_sel));
            end
        end else if (pause) begin
            m_mode = M_PAUSE;
        end else if (SKIP_ON && skip) begin
            nxt = (m_beat / 16 + 1) * 16;
            m_tick = 1'b1;
            m_elapsed = 0;
            if (m_mode == M_PLAY) m_len = beat_len(int'(tempo_sel));
            if (nxt < LEN) m_beat = nxt;
            else model_end_of_song();
        end else if (m_mode == M_PAUSE) begin
            if (play) m_mode = M_PLAY;
        end else begin
            m_elapsed++;
            if (m_elapsed == m_len) begin
                m_elapsed = 0;
                m_tick = 1'b1;
                m_len = beat_len(int'(tempo_sel));
                m_beat++;
                if (m_beat == LEN) model_end_of_song();
            end
        end
    endtask

    // One clock: model sees the same inputs the DUT samples; outputs read 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; play = 1'b1; loop_en = 1'b1;
        cycle(); cycle();
        rst = 1'b0; play = 1'b0;
        n_cmp++;
        if ({beat_num, beat_tick, playing, paused, done} !== {8'd0, 4'b0000}) begin
            n_bad++;
            $display("FAIL reset: beat=%0d tick=%b play=%b pause=%b done=%b, want all zero",
                     beat_num, beat_tick, playing, paused, done);
        end
        pause = 1'b1; cycle(); pause = 1'b0;
        n_cmp++;
        if (paused !== 1'b0 || playing !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_pause: paused=%b playing=%b, want 0 0", paused, playing);
        end
    endtask

    task automatic test_loop();
        int exp_beat;
        bit exp_tick;
        stop = 1'b1; cycle(); stop = 1'b0;
        tempo_sel = 2'd0; loop_en = 1'b1;
        play = 1'b1; cycle(); play = 1'b0;
        n_cmp++;
        if (playing !== 1'b1 || beat_num !== 8'd0 || beat_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL loop_start: playing=%b beat=%0d tick=%b, want 1 0 0", playing, beat_num, beat_tick);
        end
        for (int b = 1; b <= 33; b++) begin
            for (int k = 1; k <= 4; k++) begin
                cycle();
                exp_tick = (k == 4);
                exp_beat = (k == 4) ? (b % LEN) : ((b - 1) % LEN);
                n_cmp++;
                if (beat_tick !== exp_tick || beat_num !== 8'(exp_beat) || done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL loop_seq b=%0d k=%0d: beat=%0d tick=%b done=%b, want beat=%0d tick=%b done=0",
                             b, k, beat_num, beat_tick, done, exp_beat, exp_tick);
                end
            end
        end
    endtask

    task automatic test_end_of_song();
        stop = 1'b1; cycle(); stop = 1'b0;
        tempo_sel = 2'd0; loop_en = 1'b0;
        play = 1'b1; cycle(); play = 1'b0;
        repeat (124) cycle();
        n_cmp++;
        if (beat_num !== 8'd31 || playing !== 1'b1) begin
            n_bad++;
            $display("FAIL end_last: beat=%0d playing=%b, want 31 1", beat_num, playing);
        end
        repeat (3) cycle();
        n_cmp++;
        if (beat_tick !== 1'b0 || done !== 1'b0 || beat_num !== 8'd31) begin
            n_bad++;
            $display("FAIL end_early: tick=%b done=%b beat=%0d, want 0 0 31", beat_tick, done, beat_num);
        end
        cycle();
        n_cmp++;
        if ({done, beat_tick, playing} !== 3'b110 || beat_num !== 8'd0) begin
            n_bad++;
            $display("FAIL end_done: done=%b tick=%b playing=%b beat=%0d, want 1 1 0 0",
                     done, beat_tick, playing, beat_num);
        end
        cycle();
        n_cmp++;
        if (done !== 1'b0 || playing !== 1'b0 || beat_num !== 8'd0) begin
            n_bad++;
            $display("FAIL end_after: done=%b playing=%b beat=%0d, want 0 0 0", done, playing, beat_num);
        end
    endtask

    task automatic test_pause_resume();
        stop = 1'b1; cycle(); stop = 1'b0;
        tempo_sel = 2'd0; loop_en = 1'b1;
        play = 1'b1; cycle(); play = 1'b0;
        repeat (22) cycle();
        pause = 1'b1; cycle(); pause = 1'b0;
        n_cmp++;
        if (paused !== 1'b1 || playing !== 1'b0 || beat_num !== 8'd5) begin
            n_bad++;
            $display("FAIL pause_enter: paused=%b playing=%b beat=%0d, want 1 0 5", paused, playing, beat_num);
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_cmp++;
            if (paused !== 1'b1 || beat_num !== 8'd5 || beat_tick !== 1'b0) begin
                n_bad++;
                $display("FAIL pause_hold i=%0d: paused=%b beat=%0d tick=%b, want 1 5 0",
                         i, paused, beat_num, beat_tick);
            end
        end
        play = 1'b1; cycle(); play = 1'b0;
        n_cmp++;
        if (playing !== 1'b1 || paused !== 1'b0 || beat_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL resume: playing=%b paused=%b tick=%b, want 1 0 0", playing, paused, beat_tick);
        end
        cycle();
        n_cmp++;
        if (beat_tick !== 1'b0 || beat_num !== 8'd5) begin
            n_bad++;
            $display("FAIL resume_wait: tick=%b beat=%0d, want 0 5", beat_tick, beat_num);
        end
        cycle();
        n_cmp++;
        if (beat_tick !== 1'b1 || beat_num !== 8'd6) begin
            n_bad++;
            $display("FAIL resume_tick: tick=%b beat=%0d, want 1 6", beat_tick, beat_num);
        end
    endtask

    task automatic test_pause_terminal();
        stop = 1'b1; cycle(); stop = 1'b0;
        tempo_sel = 2'd0; loop_en = 1'b1;
        play = 1'b1; cycle(); play = 1'b0;
        repeat (3) cycle();
        pause = 1'b1; cycle(); pause = 1'b0;
        n_cmp++;
        if (beat_tick !== 1'b0 || paused !== 1'b1 || beat_num !== 8'd0) begin
            n_bad++;
            $display("FAIL term_pause: tick=%b paused=%b beat=%0d, want 0 1 0", beat_tick, paused, beat_num);
        end
        repeat (5) cycle();
        play = 1'b1; cycle(); play = 1'b0;
        n_cmp++;
        if (beat_tick !== 1'b0 || playing !== 1'b1) begin
            n_bad++;
            $display("FAIL term_resume: tick=%b playing=%b, want 0 1", beat_tick, playing);
        end
        cycle();
        n_cmp++;
        if (beat_tick !== 1'b1 || beat_num !== 8'd1) begin
            n_bad++;
            $display("FAIL term_tick: tick=%b beat=%0d, want 1 1", beat_tick, beat_num);
        end
    endtask

    task automatic test_tempo();
        // expected tick flag and beat after each clock 2..16 following play
        bit exp_tick [2:16];
        int exp_beat [2:16];
        stop = 1'b1; cycle(); stop = 1'b0;
        tempo_sel = 2'd0; loop_en = 1'b1;
        play = 1'b1; cycle(); play = 1'b0;
        cycle();
        tempo_sel = 2'd3;
        for (int c = 2; c <= 16; c++) begin
            exp_tick[c] = (c >= 4 && c <= 8) || c == 16;
            exp_beat[c] = (c < 4) ? 0 : (c <= 8) ? c - 3 : (c < 16) ? 5 : 6;
        end
        for (int c = 2; c <= 16; c++) begin
            cycle();
            if (c == 7) tempo_sel = 2'd2;
            n_cmp++;
            if (beat_tick !== exp_tick[c] || beat_num !== 8'(exp_beat[c])) begin
                n_bad++;
                $display("FAIL tempo c=%0d: tick=%b beat=%0d, want tick=%b beat=%0d",
                         c, beat_tick, beat_num, exp_tick[c], exp_beat[c]);
            end
        end
        tempo_sel = 2'd0;
    endtask

    task automatic test_stop_play();
        stop = 1'b1; cycle(); stop = 1'b0;
        tempo_sel = 2'd0; loop_en = 1'b1;
        play = 1'b1; cycle(); play = 1'b0;
        repeat (41) cycle();
        n_cmp++;
        if (beat_num !== 8'd10) begin
            n_bad++;
            $display("FAIL stop_pre: beat=%0d, want 10", beat_num);
        end
        stop = 1'b1; play = 1'b1; cycle(); stop = 1'b0; play = 1'b0;
        n_cmp++;
        if ({beat_num, beat_tick, playing, paused} !== {8'd0, 3'b000}) begin
            n_bad++;
            $display("FAIL stop_wins: beat=%0d tick=%b playing=%b paused=%b, want 0 0 0 0",
                     beat_num, beat_tick, playing, paused);
        end
        repeat (5) cycle();
        n_cmp++;
        if (beat_num !== 8'd0 || playing !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_idle: beat=%0d playing=%b, want 0 0", beat_num, playing);
        end
    endtask

`ifdef SEQ_MEASURE_SKIP_EN
    task automatic test_skip();
        stop = 1'b1; cycle(); stop = 1'b0;
        tempo_sel = 2'd0; loop_en = 1'b1;
        play = 1'b1; cycle(); play = 1'b0;
        repeat (20) cycle();
        skip = 1'b1; cycle(); skip = 1'b0;
        n_cmp++;
        if (beat_num !== 8'd16 || beat_tick !== 1'b1 || playing !== 1'b1) begin
            n_bad++;
            $display("FAIL skip_jump: beat=%0d tick=%b playing=%b, want 16 1 1", beat_num, beat_tick, playing);
        end
        repeat (4) cycle();
        n_cmp++;
        if (beat_num !== 8'd17 || beat_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL skip_next: beat=%0d tick=%b, want 17 1", beat_num, beat_tick);
        end
        repeat (12) cycle();
        loop_en = 1'b0;
        skip = 1'b1; cycle(); skip = 1'b0;
        n_cmp++;
        if ({done, beat_tick, playing} !== 3'b110 || beat_num !== 8'd0) begin
            n_bad++;
            $display("FAIL skip_end: done=%b tick=%b playing=%b beat=%0d, want 1 1 0 0",
                     done, beat_tick, playing, beat_num);
        end
    endtask
`endif

    task automatic test_random();
        int shown = 0;
        logic [11:0] got, want;
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 499) == 0);
            stop  = ($urandom_range(0, 63) == 0);
            pause = ($urandom_range(0, 31) == 0);
            play  = ($urandom_range(0, 7) == 0);
            skip  = ($urandom_range(0, 47) == 0);
            if ($urandom_range(0, 63) == 0) loop_en = ~loop_en;
            if ($urandom_range(0, 31) == 0) tempo_sel = 2'($urandom_range(0, 3));
            cycle();
            got  = {beat_num, beat_tick, playing, paused, done};
            want = {8'(m_beat), m_tick, (m_mode == M_PLAY), (m_mode == M_PAUSE), m_done};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random i=%0d: {beat,tick,play,pause,done} got %h want %h", i, got, want);
                end
            end
        end
        rst = 1'b0; stop = 1'b0; pause = 1'b0; play = 1'b0; skip = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loop();
        test_end_of_song();
        test_pause_resume();
        test_pause_terminal();
        test_tempo();
        test_stop_play();
`ifdef SEQ_MEASURE_SKIP_EN
        test_skip();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
